fp_norm_round: RTL and testbench

- Post-addition normalize-and-round stage for single-precision floating point.
- Sits directly downstream of the FP add/sub datapath.
- Consumes the raw aligned sum: sign, exponent of the larger operand, and the extended mantissa with carry, hidden, guard and round bits plus a sticky bit.
- Produces a packed IEEE-754 word, rounded to nearest-even, with a one-cycle done pulse.

---
 rtl/fp_norm_round_if.sv | 43 ++++
 rtl/fp_norm_round.sv | 191 +++++++++++++++++++
 tb/tb_fp_norm_round.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_norm_round_if.sv
// rtl/fp_norm_round_if.sv - launch/result bundle for the fp_norm_round stage
//
// Purpose : groups the request fields (start, raw aligned sum) and the
//           response fields (packed result, done pulse, busy, flags) of the
//           normalize-and-round stage.
// Signals :
//   start      launch request, sampled only while busy=0
//   in_sign    sign of the raw sum
//   in_exp     biased exponent of the larger operand (0 is treated as 1)
//   in_mant    {carry, hidden, fraction[FRAC_W-1:0], guard, round}
//   in_sticky  OR of all bits shifted out below the round bit
//   result     packed {sign, exp, frac}, held until the next done
//   done       one-cycle pulse when result is valid
//   busy       high while a job is in flight
//   ovf        result overflowed to infinity (valid with done, held)
//   inexact    guard/round/sticky nonzero at rounding (valid with done, held)
// Modports: master drives the request side, slave is the stage itself.

interface fp_norm_round_if #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
);
    logic                      start;
    logic                      in_sign;
    logic [EXP_W-1:0]          in_exp;
    logic [FRAC_W+3:0]         in_mant;
    logic                      in_sticky;
    logic [EXP_W+FRAC_W:0]     result;
    logic                      done;
    logic                      busy;
    logic                      ovf;
    logic                      inexact;

    modport master (
        output start, in_sign, in_exp, in_mant, in_sticky,
        input  result, done, busy, ovf, inexact
    );

    modport slave (
        input  start, in_sign, in_exp, in_mant, in_sticky,
        output result, done, busy, ovf, inexact
    );
endinterface

// File: rtl/fp_norm_round.sv
// rtl/fp_norm_round.sv - post-addition normalize and round-to-nearest-even stage
//
// Purpose : takes the raw aligned sum from the FP add/sub datapath,
//           normalizes it (right shift on carry, left shift on cancellation,
//           stopping at the denormal boundary), rounds to nearest-even and
//           packs an IEEE-754 word with a one-cycle done pulse.
// Ports   :
//   clk    clock
//   reset  asynchronous, active-high reset
//   bus    fp_norm_round_if.slave (start/in_* request, result/done/busy/
//          ovf/inexact response)
// Build option:
//   FP_NORM_LZC_EN  when defined, the cancellation left shift is done in one
//                   cycle using a leading-zero count; otherwise one bit per
//                   cycle. Results and flags are identical in both builds.

module fp_norm_round #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic            clk,
    input  logic            reset,
    fp_norm_round_if.slave  bus
);
    localparam int MW      = FRAC_W + 4;        // carry, hidden, frac, G, R
    localparam int XW      = EXP_W + 2;         // exponent never wraps
    localparam int EXP_MAX = (1 << EXP_W) - 1;

    typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_DONE} state_t;

    state_t                   r_state;
    logic                     r_sign;
    logic signed [XW-1:0]     r_exp;
    logic [MW-1:0]            r_mant;
    logic                     r_sticky;
    logic [EXP_W+FRAC_W:0]    r_result;
    logic                     r_done;
    logic                     r_busy;
    logic                     r_ovf;
    logic                     r_inexact;

    // Left-shift step used by cancellation normalization.
    logic [MW-1:0]            w_lmant;
    logic signed [XW-1:0]     w_lexp;

`ifdef FP_NORM_LZC_EN
    int w_lz;
    int w_lim;
    int w_sh;

    // Leading zeros are counted over hidden..round so a guard/round bit can
    // become the hidden bit exactly as the iterative shifter would do it.
    // An all-zero mantissa reports a count larger than any exponent limit,
    // so the shift then stops at the denormal boundary.
    always_comb begin
        w_lz = 1 << XW;
        for (int i = 0; i < MW - 1; i++) begin
            if (r_mant[i]) begin
                w_lz = MW - 2 - i;
            end
        end
        w_lim   = int'(r_exp) - 1;
        w_sh    = (w_lz < w_lim) ? w_lz : w_lim;
        w_lmant = r_mant << w_sh;
        w_lexp  = r_exp - XW'(w_sh);
    end

    localparam state_t LEFT_NEXT = S_ROUND;
`else
    always_comb begin
        w_lmant = r_mant << 1;
        w_lexp  = r_exp - XW'(1);
    end

    localparam state_t LEFT_NEXT = S_NORM;
`endif

    // Rounding datapath: hidden+fraction with one spare bit for the carry.
    logic                     w_up;
    logic [FRAC_W+1:0]        w_sum;
    logic [FRAC_W+1:0]        w_rmant;
    logic signed [XW-1:0]     w_rexp;
    logic [EXP_W-1:0]         w_rexp_field;
    logic                     w_rovf;
    logic                     w_rinexact;
    logic [EXP_W+FRAC_W:0]    w_rresult;

    always_comb begin
        w_up  = r_mant[1] & (r_mant[0] | r_sticky | r_mant[2]);
        w_sum = {1'b0, r_mant[MW-2:2]} + {{(FRAC_W+1){1'b0}}, w_up};
        if (w_sum[FRAC_W+1]) begin
            w_rmant = w_sum >> 1;
            w_rexp  = r_exp + XW'(1);
        end else begin
            w_rmant = w_sum;
            w_rexp  = r_exp;
        end
        // A denormal that rounds up into the hidden bit naturally gets exp 1.
        w_rexp_field = w_rmant[FRAC_W] ? w_rexp[EXP_W-1:0] : '0;
        w_rovf       = (int'(w_rexp) >= EXP_MAX);
        w_rinexact   = r_mant[1] | r_mant[0] | r_sticky;
        if (w_rovf) begin
            w_rresult = {r_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else begin
            w_rresult = {r_sign, w_rexp_field, w_rmant[FRAC_W-1:0]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_sign    <= 1'b0;
            r_exp     <= '0;
            r_mant    <= '0;
            r_sticky  <= 1'b0;
            r_result  <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_ovf     <= 1'b0;
            r_inexact <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_sign   <= bus.in_sign;
                        r_exp    <= (bus.in_exp == '0) ? XW'(1) : XW'(bus.in_exp);
                        r_mant   <= bus.in_mant;
                        r_sticky <= bus.in_sticky;
                        r_busy   <= 1'b1;
                        r_state  <= S_NORM;
                    end
                end

                S_NORM: begin
                    if (int'(r_exp) == EXP_MAX) begin
                        // Inf/NaN passes through with its payload.
                        r_result  <= {r_sign, {EXP_W{1'b1}}, r_mant[MW-3:2]};
                        r_ovf     <= 1'b0;
                        r_inexact <= 1'b0;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_DONE;
                    end else if (r_mant == '0 && !r_sticky) begin
                        // Exact cancellation always yields +0.
                        r_result  <= '0;
                        r_ovf     <= 1'b0;
                        r_inexact <= 1'b0;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_DONE;
                    end else if (r_mant[MW-1]) begin
                        r_mant   <= r_mant >> 1;
                        r_sticky <= r_sticky | r_mant[0];
                        r_exp    <= r_exp + XW'(1);
                        r_state  <= S_ROUND;
                    end else if (!r_mant[MW-2] && int'(r_exp) > 1) begin
                        r_mant  <= w_lmant;
                        r_exp   <= w_lexp;
                        r_state <= LEFT_NEXT;
                    end else begin
                        r_state <= S_ROUND;
                    end
                end

                S_ROUND: begin
                    r_result  <= w_rresult;
                    r_ovf     <= w_rovf;
                    r_inexact <= w_rinexact;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= S_DONE;
                end

                S_DONE: begin
                    // start is deliberately not looked at here.
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.result  = r_result;
    assign bus.done    = r_done;
    assign bus.busy    = r_busy;
    assign bus.ovf     = r_ovf;
    assign bus.inexact = r_inexact;

endmodule

// File: tb/tb_fp_norm_round.sv
// tb/tb_fp_norm_round.sv - self-checking bench for fp_norm_round

module tb_fp_norm_round;
    logic clk;
    logic reset;
    int   cyc;
    int   total;
    int   bad;

    fp_norm_round_if bus ();

    fp_norm_round dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        inx;
        int          lat;
        int          t0;
    } exp_t;

    exp_t q_exp[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Value-level reference: the input is an exact real number
    // (-1)^s * (mant + sticky*eps) * 2^(e-...); find its leading one, pick the
    // IEEE exponent (clamped at 1 for denormals), drop the bits below the
    // fraction LSB and round to nearest-even on the dropped remainder.
    // Sticky sits 32 bits below the round bit so it behaves as an
    // infinitesimal for any realistic left shift.
    function automatic void model(input logic s, input logic [7:0] ex,
                                  input logic [26:0] m, input logic st,
                                  output logic [31:0] res, output logic ovf,
                                  output logic inx, output int lat);
        int e, p, big_e, d, k;
        longint unsigned x, q, rem, half;
        e   = (ex == 8'd0) ? 1 : int'(ex);
        ovf = 1'b0;
        inx = 1'b0;
        if (ex == 8'hFF) begin
            res = {s, 8'hFF, m[24:2]};
            lat = 2;
            return;
        end
        if (m == 27'd0 && !st) begin
            res = 32'd0;
            lat = 2;
            return;
        end
        if (m == 27'd0) begin
            res = {s, 31'd0};
            inx = 1'b1;
`ifdef FP_NORM_LZC_EN
            lat = 3;
`else
            lat = 3 + (e - 1);
`endif
            return;
        end
        x = (64'(m) << 32) | 64'(st);
        p = 0;
        for (int i = 0; i < 64; i++) if (x[i]) p = i;
        big_e = e + p - 57;
        if (big_e < 1) big_e = 1;
        k = (big_e < e) ? e - big_e : 0;
`ifdef FP_NORM_LZC_EN
        lat = 3;
`else
        lat = 3 + k;
`endif
        d    = 34 + big_e - e;
        q    = x >> d;
        rem  = x & ((64'd1 << d) - 64'd1);
        half = 64'd1 << (d - 1);
        inx  = (rem != 64'd0);
        if (rem > half || (rem == half && q[0])) q = q + 64'd1;
        if (q >= (64'd1 << 24)) begin
            q     = q >> 1;
            big_e = big_e + 1;
        end
        if (big_e >= 255) begin
            res = {s, 8'hFF, 23'd0};
            ovf = 1'b1;
        end else begin
            res = {s, (q[23] ? 8'(big_e) : 8'd0), q[22:0]};
        end
    endfunction

    // Compare process: every done is matched against the oldest expectation;
    // while a job is in flight (after its start edge) busy must be high.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.done) begin
                if (q_exp.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 expected done=0");
                end else begin
                    exp_t x;
                    x = q_exp.pop_front();
                    chk("result",  bus.result,        x.res);
                    chk("ovf",     32'(bus.ovf),      32'(x.ovf));
                    chk("inexact", 32'(bus.inexact),  32'(x.inx));
                    chk("latency", 32'(cyc - x.t0),   32'(x.lat));
                    chk("busy_at_done", 32'(bus.busy), 32'd0);
                end
            end else if (q_exp.size() != 0 && cyc > q_exp[0].t0) begin
                chk("busy_in_flight", 32'(bus.busy), 32'd1);
            end
        end
    end

    task automatic run_job(input logic s, input logic [7:0] ex,
                           input logic [26:0] m, input logic st);
        exp_t x;
        int   n;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.in_sign   = s;
        bus.in_exp    = ex;
        bus.in_mant   = m;
        bus.in_sticky = st;
        model(s, ex, m, st, x.res, x.ovf, x.inx, x.lat);
        x.t0 = cyc;
        q_exp.push_back(x);
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done) begin
            total++;
            bad++;
            $display("FAIL timeout: got no done expected done within 400 cycles");
            q_exp.delete();
        end
    endtask

    task automatic pin(input string name, input logic s, input logic [7:0] ex,
                       input logic [26:0] m, input logic st,
                       input logic [31:0] req_res, input int req_lat);
        logic [31:0] r;
        logic        o;
        logic        i;
        int          l;
        model(s, ex, m, st, r, o, i, l);
        chk({name, "_model_res"}, r, req_res);
        chk({name, "_model_lat"}, 32'(l), 32'(req_lat));
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        cyc           = 0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = 8'd0;
        bus.in_mant   = 27'd0;
        bus.in_sticky = 1'b0;

        // Hand-computed pins on the reference model.
        pin("carry",   1'b0, 8'd127, 27'h4000000, 1'b0, 32'h40000000, 3);
`ifdef FP_NORM_LZC_EN
        pin("cancel",  1'b0, 8'd127, 27'h0800000, 1'b0, 32'h3E800000, 3);
`else
        pin("cancel",  1'b0, 8'd127, 27'h0800000, 1'b0, 32'h3E800000, 5);
`endif
        pin("tie_up",  1'b0, 8'd127, 27'h2000006, 1'b0, 32'h3F800002, 3);
        pin("tie_even",1'b0, 8'd127, 27'h2000002, 1'b0, 32'h3F800000, 3);
        pin("ovf",     1'b1, 8'd254, 27'h4000000, 1'b0, 32'hFF800000, 3);
        pin("zero",    1'b1, 8'd127, 27'h0000000, 1'b0, 32'h00000000, 2);
        pin("denorm",  1'b0, 8'd1,   27'h0000004, 1'b0, 32'h00000001, 3);

        repeat (3) @(negedge clk);
        chk("reset_result",  bus.result,        32'd0);
        chk("reset_done",    32'(bus.done),     32'd0);
        chk("reset_busy",    32'(bus.busy),     32'd0);
        chk("reset_ovf",     32'(bus.ovf),      32'd0);
        chk("reset_inexact", 32'(bus.inexact),  32'd0);
        reset = 1'b0;

        run_job(1'b0, 8'd127, 27'h4000000, 1'b0);   // carry
        run_job(1'b0, 8'd127, 27'h0800000, 1'b0);   // two left shifts
        run_job(1'b0, 8'd127, 27'h2000006, 1'b0);   // tie, round up to even
        run_job(1'b0, 8'd127, 27'h2000002, 1'b0);   // tie, stays even
        run_job(1'b0, 8'd127, 27'h2000002, 1'b1);   // sticky breaks the tie
        run_job(1'b1, 8'd254, 27'h4000000, 1'b0);   // overflow via carry
        run_job(1'b1, 8'd127, 27'h0000000, 1'b0);   // exact zero is +0
        run_job(1'b0, 8'd1,   27'h0000004, 1'b0);   // smallest denormal
        run_job(1'b0, 8'd0,   27'h2000000, 1'b0);   // exp 0 treated as 1
        run_job(1'b0, 8'hFF,  27'h0000006, 1'b0);   // special passthrough
        run_job(1'b0, 8'd127, 27'h3FFFFFE, 1'b0);   // rounding carries out
        run_job(1'b0, 8'd3,   27'h0100000, 1'b0);   // shifts stop at denormal
        run_job(1'b1, 8'd4,   27'h0000000, 1'b1);   // sticky only -> -0 inexact
        run_job(1'b1, 8'd100, 27'h1234567, 1'b1);   // generic shift + round
        run_job(1'b0, 8'd254, 27'h3FFFFFE, 1'b0);   // overflow via rounding

        // Reset in the middle of a 10-shift job: no done, all outputs cleared.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.in_sign   = 1'b0;
        bus.in_exp    = 8'd127;
        bus.in_mant   = 27'h0008000;
        bus.in_sticky = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midreset_result",  bus.result,       32'd0);
        chk("midreset_done",    32'(bus.done),    32'd0);
        chk("midreset_busy",    32'(bus.busy),    32'd0);
        chk("midreset_ovf",     32'(bus.ovf),     32'd0);
        chk("midreset_inexact", 32'(bus.inexact), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_reset_idle_busy", 32'(bus.busy), 32'd0);

        run_job(1'b0, 8'd127, 27'h0008000, 1'b0);   // same job, now completes
        run_job(1'b1, 8'd127, 27'h2000006, 1'b0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
